// File: rtl/hb_pkg.sv
// Shared definitions for the time-multiplexed halfband decimator:
// geometry constants, sequencer state encoding and the Q15 coefficient set.
package hb_pkg;

   localparam int         NTAPS      = 27;
   localparam int         NPAIRS     = 7;
   localparam int         PTR_W      = 5;
   localparam logic [2:0] CENTER_SEL = 3'd7;
   localparam logic [4:0] COUNT_FULL = 5'd27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAIR,
      ST_CENTER,
      ST_DRAIN
   } hb_state_e;

   typedef logic signed [15:0] coef_t;

   // Unique symmetric-pair coefficients, outermost pair first; the center tap is 0.5.
   localparam coef_t HB_COEF [NPAIRS] = '{
      -16'sd33, 16'sd110, -16'sd285, 16'sd630, -16'sd1290, 16'sd2950, 16'sd6110
   };
   localparam coef_t HB_CENTER = 16'sd16384;

endpackage

// File: rtl/hb_tap_addr.sv
// Circular-buffer read address generation for one symmetric-pair step
// (or the center tap) relative to the newest sample at base.
module hb_tap_addr
   import hb_pkg::*;
(
   input  logic [PTR_W-1:0] base,
   input  logic [2:0]       k,
   input  logic             center,
   output logic [PTR_W-1:0] addr_a,
   output logic [PTR_W-1:0] addr_b
);

   logic [PTR_W-1:0] k2;

   always_comb begin
      k2 = {1'b0, k, 1'b0};
      if (center) begin
         addr_a = base - 5'd13;
         addr_b = base - 5'd13;
      end else begin
         addr_a = base - k2;
         addr_b = base - (5'd26 - k2);
      end
   end

endmodule

// File: rtl/hb_mac_sched.sv
// Halfband decimator sequencer: buffer write addressing, launch detection and
// the 8-step symmetric-pair MAC issue sequence with registered issue outputs.
module hb_mac_sched
   import hb_pkg::*;
#(
   parameter int MAC_LAT = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             x_in_valid,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_addr,
   output logic [PTR_W-1:0] rd_addr_a,
   output logic [PTR_W-1:0] rd_addr_b,
   output logic [2:0]       coef_sel,
   output logic             mac_en,
   output logic             mac_clr,
   output logic             mac_last,
   output logic             y_load,
   output logic             busy,
   output logic             overrun
);

   localparam int          DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

   hb_state_e        state_q, state_d;
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [4:0]       count_q, count_d;
   logic             phase_q, phase_d;
   logic [2:0]       k_q, k_d;
   logic [PTR_W-1:0] base_q, base_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic             overrun_q, overrun_d;

   logic [PTR_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
   logic [2:0]       coef_q, coef_d;
   logic             mac_en_q, mac_en_d;
   logic             mac_clr_q, mac_clr_d;
   logic             mac_last_q, mac_last_d;
   logic             y_load_q, y_load_d;
   logic             busy_q, busy_d;

   logic             launch, drain_done;
   logic [PTR_W-1:0] addr_a, addr_b;

   // Addresses are computed from the next state so the issue outputs can be registered.
   hb_tap_addr u_tap_addr (
      .base   (base_d),
      .k      (k_d),
      .center (state_d == ST_CENTER),
      .addr_a (addr_a),
      .addr_b (addr_b)
   );

   always_comb begin
      wr_en      = x_in_valid;
      wr_addr    = wp_q;
      launch     = x_in_valid && phase_q && (count_q == COUNT_FULL);
      drain_done = (state_q == ST_DRAIN) && (dcnt_q == DRAIN_LAST);

      wp_d    = wp_q;
      count_d = count_q;
      phase_d = phase_q;
      if (x_in_valid) begin
         wp_d    = wp_q + 5'd1;
         phase_d = ~phase_q;
         if (count_q != COUNT_FULL) count_d = count_q + 5'd1;
      end

      state_d   = state_q;
      k_d       = k_q;
      base_d    = base_q;
      dcnt_d    = dcnt_q;
      overrun_d = overrun_q;

      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               state_d = ST_PAIR;
               k_d     = 3'd0;
               base_d  = wp_q;
            end
         end
         ST_PAIR: begin
            if (k_q == 3'(NPAIRS - 1)) state_d = ST_CENTER;
            else                       k_d     = k_q + 3'd1;
         end
         ST_CENTER: begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
         end
         ST_DRAIN: begin
            if (drain_done) begin
               if (launch) begin
                  state_d = ST_PAIR;
                  k_d     = 3'd0;
                  base_d  = wp_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The y_load cycle is the one busy cycle in which a launch is accepted.
      if (launch && (state_q != ST_IDLE) && !drain_done) overrun_d = 1'b1;

      mac_en_d   = (state_d == ST_PAIR) || (state_d == ST_CENTER);
      mac_clr_d  = (state_d == ST_PAIR) && (k_d == 3'd0);
      mac_last_d = (state_d == ST_CENTER);
      coef_d     = (state_d == ST_CENTER) ? CENTER_SEL :
                   (state_d == ST_PAIR)   ? k_d : 3'd0;
      rd_a_d     = mac_en_d ? addr_a : '0;
      rd_b_d     = (state_d == ST_PAIR) ? addr_b : '0;
      y_load_d   = (state_d == ST_DRAIN) && (dcnt_d == DRAIN_LAST);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         wp_q       <= '0;
         count_q    <= '0;
         phase_q    <= 1'b0;
         k_q        <= '0;
         base_q     <= '0;
         dcnt_q     <= '0;
         overrun_q  <= 1'b0;
         rd_a_q     <= '0;
         rd_b_q     <= '0;
         coef_q     <= '0;
         mac_en_q   <= 1'b0;
         mac_clr_q  <= 1'b0;
         mac_last_q <= 1'b0;
         y_load_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         count_q    <= count_d;
         phase_q    <= phase_d;
         k_q        <= k_d;
         base_q     <= base_d;
         dcnt_q     <= dcnt_d;
         overrun_q  <= overrun_d;
         rd_a_q     <= rd_a_d;
         rd_b_q     <= rd_b_d;
         coef_q     <= coef_d;
         mac_en_q   <= mac_en_d;
         mac_clr_q  <= mac_clr_d;
         mac_last_q <= mac_last_d;
         y_load_q   <= y_load_d;
         busy_q     <= busy_d;
      end
   end

   assign rd_addr_a = rd_a_q;
   assign rd_addr_b = rd_b_q;
   assign coef_sel  = coef_q;
   assign mac_en    = mac_en_q;
   assign mac_clr   = mac_clr_q;
   assign mac_last  = mac_last_q;
   assign y_load    = y_load_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_hb_mac_sched.sv
// Directed bench for hb_mac_sched: priming, first sequence from a vector table,
// back-to-back launch, pointer wrap, overrun and mid-sequence reset.
module tb_hb_mac_sched;
   import hb_pkg::*;

   localparam int MAC_LAT = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       x_in_valid;
   logic       wr_en, mac_en, mac_clr, mac_last, y_load, busy, overrun;
   logic [4:0] wr_addr, rd_addr_a, rd_addr_b;
   logic [2:0] coef_sel;

   logic [4:0] ta_base, ta_a, ta_b;
   logic [2:0] ta_k;
   logic       ta_center;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hb_mac_sched #(.MAC_LAT(MAC_LAT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .x_in_valid (x_in_valid),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .coef_sel   (coef_sel),
      .mac_en     (mac_en),
      .mac_clr    (mac_clr),
      .mac_last   (mac_last),
      .y_load     (y_load),
      .busy       (busy),
      .overrun    (overrun)
   );

   hb_tap_addr u_ta (
      .base   (ta_base),
      .k      (ta_k),
      .center (ta_center),
      .addr_a (ta_a),
      .addr_b (ta_b)
   );

   typedef struct {
      logic       x;
      logic       en, clr, last, yl, bz;
      logic [2:0] coef;
      logic [4:0] ra, rb;
      logic       crb;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic v);
      @(posedge clk);
      #1 x_in_valid = v;
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_wr_en"},    wr_en,     0);
      chk({tag, "_wr_addr"},  wr_addr,   0);
      chk({tag, "_rd_a"},     rd_addr_a, 0);
      chk({tag, "_rd_b"},     rd_addr_b, 0);
      chk({tag, "_coef"},     coef_sel,  0);
      chk({tag, "_mac_en"},   mac_en,    0);
      chk({tag, "_mac_clr"},  mac_clr,   0);
      chk({tag, "_mac_last"}, mac_last,  0);
      chk({tag, "_y_load"},   y_load,    0);
      chk({tag, "_busy"},     busy,      0);
      chk({tag, "_overrun"},  overrun,   0);
   endtask

   // Launch (unless pre: launch already happened in the previous cycle) and
   // check every cycle of the sequence against base-relative tap positions.
   task automatic launch_and_check(input logic [4:0] base, input logic [15:0] mask,
                                   input int ovr_at, input bit pre);
      logic [4:0] ea, eb;
      int k;
      if (!pre) begin
         step(1'b1);
         chk("launch_wr_addr", wr_addr, base);
         chk("launch_busy", busy, 0);
         chk("launch_overrun", overrun, (ovr_at <= 0) ? 1 : 0);
      end
      for (int off = 1; off <= 8 + MAC_LAT; off++) begin
         step(mask[off]);
         chk("seq_busy", busy, 1);
         chk("seq_overrun", overrun, (off >= ovr_at) ? 1 : 0);
         chk("seq_y_load", y_load, (off == 8 + MAC_LAT) ? 1 : 0);
         if (off <= 7) begin
            k  = off - 1;
            ea = base - 5'(2 * k);
            eb = base - 5'(26 - 2 * k);
            chk("pair_mac_en", mac_en, 1);
            chk("pair_mac_clr", mac_clr, (k == 0) ? 1 : 0);
            chk("pair_mac_last", mac_last, 0);
            chk("pair_coef", coef_sel, k);
            chk("pair_rd_a", rd_addr_a, ea);
            chk("pair_rd_b", rd_addr_b, eb);
         end else if (off == 8) begin
            ea = base - 5'd13;
            chk("center_mac_en", mac_en, 1);
            chk("center_mac_clr", mac_clr, 0);
            chk("center_mac_last", mac_last, 1);
            chk("center_coef", coef_sel, 7);
            chk("center_rd_a", rd_addr_a, ea);
         end else begin
            chk("drain_mac_en", mac_en, 0);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;

      //      x   en  clr last yl  bz  coef   ra     rb    crb
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  5'd0,  1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 5'd27, 5'd1,  1'b1};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 5'd25, 5'd3,  1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 5'd23, 5'd5,  1'b1};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 5'd21, 5'd7,  1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 5'd19, 5'd9,  1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 5'd17, 5'd11, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 5'd15, 5'd13, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 5'd14, 5'd0,  1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0,  5'd0,  1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0,  5'd0,  1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 5'd0,  5'd0,  1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  5'd0,  1'b0};

      reset_n    = 1'b1;
      x_in_valid = 1'b0;
      ta_base    = 5'd2;
      ta_k       = 3'd0;
      ta_center  = 1'b0;
      #2 reset_n = 1'b0;
      #10;
      chk_reset_state("reset");

      #1;
      chk("tap_b2_k0_a", ta_a, 2);
      chk("tap_b2_k0_b", ta_b, 8);
      ta_center = 1'b1;
      #1;
      chk("tap_b2_center_a", ta_a, 21);

      @(negedge clk);
      reset_n = 1'b1;

      // Priming: 27 samples never launch.
      for (int i = 0; i < 27; i++) begin
         seen = 0;
         step(1'b1);
         chk("prime_wr_en", wr_en, 1);
         chk("prime_wr_addr", wr_addr, i);
         seen = seen | mac_en | busy;
         for (int j = 0; j < 19; j++) begin
            step(1'b0);
            seen = seen | mac_en | busy | y_load;
         end
         chk("prime_quiet", seen, 0);
      end

      // First sequence: base 27.
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].x);
         if (tbl[i].x) chk("tbl_wr_addr", wr_addr, 27);
         chk("tbl_mac_en", mac_en, tbl[i].en);
         chk("tbl_mac_clr", mac_clr, tbl[i].clr);
         chk("tbl_mac_last", mac_last, tbl[i].last);
         chk("tbl_y_load", y_load, tbl[i].yl);
         chk("tbl_busy", busy, tbl[i].bz);
         chk("tbl_overrun", overrun, 0);
         if (tbl[i].en) begin
            chk("tbl_coef", coef_sel, tbl[i].coef);
            chk("tbl_rd_a", rd_addr_a, tbl[i].ra);
         end
         if (tbl[i].crb) chk("tbl_rd_b", rd_addr_b, tbl[i].rb);
      end

      // Sample 29 does not launch; sample 30 launches, sample 32 lands on y_load.
      step(1'b1);
      chk("s29_wr_addr", wr_addr, 28);
      chk("s29_busy", busy, 0);
      step(1'b0);
      launch_and_check(5'd29, 16'h0820, 99, 1'b0);
      launch_and_check(5'd31, 16'h0000, 99, 1'b1);

      // Pointer wrap: sample 33 at address 0, launch on sample 34 with base 1.
      step(1'b1);
      chk("wrap_wr_addr", wr_addr, 0);
      step(1'b0);
      chk("wrap_idle_busy", busy, 0);
      launch_and_check(5'd1, 16'h0000, 99, 1'b0);

      // Input every 2 cycles: launch at offset 4 arrives while busy.
      step(1'b1);
      step(1'b0);
      launch_and_check(5'd3, 16'h0554, 5, 1'b0);
      seen = 0;
      for (int j = 0; j < 3; j++) begin
         step(1'b0);
         seen = seen | y_load | busy;
      end
      chk("ovr_after_quiet", seen, 0);
      chk("ovr_sticky", overrun, 1);

      // Reset in the middle of a sequence (sample 42 launches).
      step(1'b1);
      for (int j = 0; j < 3; j++) step(1'b0);
      step(1'b0);
      chk("mid_mac_en", mac_en, 1);
      chk("mid_coef", coef_sel, 3);
      reset_n = 1'b0;
      #1;
      chk_reset_state("async_reset");
      seen = 0;
      for (int j = 0; j < 12; j++) begin
         step(1'b0);
         seen = seen | y_load | busy | mac_en;
      end
      chk("reset_no_y_load", seen, 0);
      reset_n = 1'b1;

      seen = 0;
      for (int i = 0; i < 27; i++) begin
         step(1'b1);
         chk("reprime_wr_addr", wr_addr, i);
         seen = seen | mac_en | busy;
         step(1'b0);
         seen = seen | mac_en | busy | y_load;
      end
      chk("reprime_quiet", seen, 0);
      launch_and_check(5'd27, 16'h0000, 99, 1'b0);
      step(1'b0);
      chk("final_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hb_mac_sched.md
# hb_mac_sched

Sequencer for the time-multiplexed halfband decimator. It owns the 32-entry circular sample buffer addressing and issues one symmetric-pair MAC operation per cycle to a single shared multiply-accumulate datapath. The 27-tap, 7-unique-coefficient Q15 filter becomes an 8-cycle issue sequence, one per decimated output. It sits between the audio sample source and the shared MAC / output register in the decimation chain.

## Interface
Parameters:
- MAC_LAT, 3, cycles from the MAC control issue to the accumulator result being valid (≥1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- x_in_valid  in  1  one-cycle strobe: a new input sample is present this cycle
- wr_en  out  1  buffer write strobe (combinational copy of x_in_valid)
- wr_addr  out  5  buffer write address (current write pointer)
- rd_addr_a  out  5  buffer read address, newer tap of the pair / center tap
- rd_addr_b  out  5  buffer read address, older tap of the pair (don't-care on the center step)
- coef_sel  out  3  coefficient index 0..6; 7 = center (0.5)
- mac_en  out  1  MAC operation valid this cycle
- mac_clr  out  1  first op of a sequence: accumulator loads instead of adding
- mac_last  out  1  final op of a sequence
- y_load  out  1  one-cycle strobe: the output register captures the accumulator >>> 15
- busy  out  1  sequence in flight
- overrun  out  1  sticky error flag, cleared only by reset

## Operation
- Write pointer wp (5-bit, wraps 31→0). On x_in_valid: wr_addr = wp, then wp increments. Writes are never blocked.
- Accept counter saturates at 27. Phase bit toggles per accepted sample and starts at 0.
- Launch request = x_in_valid && phase==1 && count==27, with both values sampled before the update. The first launch is on the 28th sample; after that, every 2nd sample.
- On launch: base ← wp (address of the newest sample). Tap i is at (base − i) mod 32.
- FSM states: IDLE, PAIR, CENTER, DRAIN.
  - IDLE → PAIR on launch, with k=0.
  - PAIR, step k=0..6: rd_addr_a = base−2k, rd_addr_b = base−(26−2k), coef_sel = k, mac_en = 1, mac_clr = (k==0). Go to CENTER after k=6.
  - CENTER: rd_addr_a = base−13, coef_sel = 7, mac_en = 1, mac_last = 1. Then DRAIN.
  - DRAIN: counts MAC_LAT cycles. y_load is asserted on the last DRAIN cycle. The next state is IDLE, or PAIR if a launch arrives in that same cycle.
- busy = (state ≠ IDLE).
- A launch request while busy, except in the y_load cycle, sets overrun. That launch is dropped, and the in-flight sequence completes normally.
- Buffer depth 32 against a span of 27 means up to 5 writes during a sequence never clobber live taps.
- All address arithmetic is 5-bit modulo.

## Timing
- Reset values: wp=0, count=0, phase=0, state=IDLE. All strobes are 0, all addresses are 0, and overrun=0.
- Launch accepted in cycle T:
  - PAIR k=0 in T+1, k=6 in T+7.
  - CENTER in T+8.
  - y_load in T+8+MAC_LAT. busy is high from T+1 through that y_load cycle.
- Minimum launch spacing is 8+MAC_LAT cycles. A launch in the y_load cycle is legal and gives PAIR k=0 in the next cycle.
- Issue outputs are registered. wr_en and wr_addr are combinational from x_in_valid and wp.
- Reset asserted mid-sequence aborts immediately. No y_load is produced, the buffer contents are forgotten, and priming restarts from 0.

## Structure
- Shared package hb_pkg holds:
  - NTAPS=27, NPAIRS=7, PTR_W=5, CENTER_SEL=3'd7
  - the FSM state enum
  - the Q15 coefficient constant array, for use by the MAC side
- Sub-module hb_tap_addr computes rd_addr_a and rd_addr_b from base, step k and the center flag. It is combinational and reused by the verification model.

## Test plan
- Reset, then 27 samples spaced 20 cycles apart: no mac_en ever, busy=0, and wr_addr runs 0..26.
- 28th sample (wr_addr=27): launch with base=27.
  - k=0 gives rd_a=27, rd_b=1; k=6 gives rd_a=15, rd_b=13; center gives rd_a=14 with coef_sel=7.
  - mac_clr only on k=0. y_load exactly 11 cycles after launch (MAC_LAT=3).
- Continuous input every 2 cycles after priming: the 2nd launch falls while busy, so overrun=1 and stays set. The first sequence still produces its single y_load.
- Launch spacing of exactly 11 cycles: the 2nd launch coincides with y_load. PAIR k=0 follows in the next cycle and overrun stays 0.
- Pointer wrap: prime, then run until wp passes 31. For a launch with base=2, rd_b at k=0 is 8 (2−26 mod 32) and center rd_a is 21.
- reset_n pulsed low at T+4 of a sequence: all outputs return to their reset values asynchronously, and there is no y_load. The next launch needs 28 fresh samples.
